// File: rtl/rgmii_phy_side_tx.sv
// PHY-side RGMII transmitter: byte source to RXC/RD/RX_CTL SDR edge pairs for an external ODDR.
// Direct DDR at 1G, nibble serialisation at 10/100, in-band status between frames.
module rgmii_phy_side_tx #(
    parameter int DIV_100M = 5,
    parameter int DIV_10M  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic       link_up,
    input  logic       full_duplex,
    input  logic [7:0] s_rxd,
    input  logic       s_rx_dv,
    input  logic       s_rx_er,
    output logic       s_rx_en,
    output logic       rgmii_rxc_1,
    output logic       rgmii_rxc_2,
    output logic [3:0] rgmii_rd_1,
    output logic [3:0] rgmii_rd_2,
    output logic       rgmii_rx_ctl_1,
    output logic       rgmii_rx_ctl_2
);

    // state  | meaning
    // STATUS | between frames: RD carries in-band status, idle byte sampled each period end
    // NIB_LO | frame byte held, low nibble on RD (at 1G: frame/extension byte on the wire)
    // NIB_HI | high nibble on RD, next byte sampled at period end
    typedef enum logic [1:0] {STATUS, NIB_LO, NIB_HI} state_t;

    localparam int CW = $clog2(DIV_10M + 1);

    function automatic logic is_1g(input logic [1:0] spd);
        return spd[1];
    endfunction

    function automatic logic [CW-1:0] last_cnt(input logic [1:0] spd);
        logic [CW-1:0] r;
        case (spd)
            2'b01:   r = CW'(DIV_100M - 1);
            2'b00:   r = CW'(DIV_10M - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [CW-1:0] high_cnt(input logic [1:0] spd);
        logic [CW-1:0] r;
        case (spd)
            2'b01:   r = CW'(DIV_100M / 2);
            2'b00:   r = CW'(DIV_10M / 2);
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      speed_q, speed_d;
    logic [7:0]      rxd_q, rxd_d;
    logic            dv_q, dv_d;
    logic            er_q, er_d;
    logic            en_q, en_d;
    logic            rxc1_q, rxc1_d;
    logic            rxc2_q, rxc2_d;
    logic [3:0]      rd1_q, rd1_d;
    logic [3:0]      rd2_q, rd2_d;
    logic            ctl1_q, ctl1_d;
    logic            ctl2_q, ctl2_d;

    logic            period_end;
    logic            sample;
    logic            is_frame;
    logic            clk_hi;
    logic [3:0]      st_nib;
    logic [3:0]      nib;

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        count_d  = count_q;
        rxd_d    = rxd_q;
        dv_d     = dv_q;
        er_d     = er_q;
        nib      = 4'h0;
        clk_hi   = 1'b0;

        period_end = (count_q == last_cnt(speed_q));
        // en_q is precomputed so it marks exactly the cycles whose inputs are taken
        sample     = en_q;
        is_frame   = s_rx_dv | s_rx_er;

        if (sample) begin
            rxd_d = s_rxd;
            dv_d  = s_rx_dv;
            er_d  = s_rx_er;
        end

        if (is_1g(speed_q)) begin
            state_d = (sample && is_frame) ? NIB_LO : STATUS;
        end else begin
            case (state_q)
                STATUS:  if (sample && is_frame) state_d = NIB_LO;
                NIB_LO:  if (period_end) state_d = NIB_HI;
                NIB_HI:  if (sample) state_d = is_frame ? NIB_LO : STATUS;
                default: state_d = STATUS;
            endcase
        end

        if (period_end && state_d == STATUS) begin
            speed_d = speed;
        end

        if (speed_d != speed_q || period_end) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end

        en_d = is_1g(speed_d) ||
               ((count_d == last_cnt(speed_d)) && (state_d != NIB_LO));

        // outputs are built from next-cycle state so they line up with count/state
        st_nib = {full_duplex, speed_d, link_up};
        rxc1_d = 1'b1;
        rxc2_d = 1'b0;
        rd1_d  = st_nib;
        rd2_d  = st_nib;
        ctl1_d = 1'b0;
        ctl2_d = 1'b0;

        if (is_1g(speed_d)) begin
            if (state_d == NIB_LO) begin
                rd1_d  = rxd_d[3:0];
                rd2_d  = rxd_d[7:4];
                ctl1_d = dv_d;
                ctl2_d = dv_d ^ er_d;
            end
        end else begin
            clk_hi = (count_d >= high_cnt(speed_d));
            rxc1_d = clk_hi;
            rxc2_d = clk_hi;
            if (state_d != STATUS) begin
                nib    = (state_d == NIB_LO) ? rxd_d[3:0] : rxd_d[7:4];
                rd1_d  = nib;
                rd2_d  = nib;
                ctl1_d = clk_hi ? (dv_d ^ er_d) : dv_d;
                ctl2_d = clk_hi ? (dv_d ^ er_d) : dv_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATUS;
            count_q <= '0;
            speed_q <= 2'b10;
            rxd_q   <= 8'h00;
            dv_q    <= 1'b0;
            er_q    <= 1'b0;
            en_q    <= 1'b0;
            rxc1_q  <= 1'b1;
            rxc2_q  <= 1'b0;
            rd1_q   <= 4'h0;
            rd2_q   <= 4'h0;
            ctl1_q  <= 1'b0;
            ctl2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            speed_q <= speed_d;
            rxd_q   <= rxd_d;
            dv_q    <= dv_d;
            er_q    <= er_d;
            en_q    <= en_d;
            rxc1_q  <= rxc1_d;
            rxc2_q  <= rxc2_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ctl1_q  <= ctl1_d;
            ctl2_q  <= ctl2_d;
        end
    end

    assign s_rx_en        = en_q;
    assign rgmii_rxc_1    = rxc1_q;
    assign rgmii_rxc_2    = rxc2_q;
    assign rgmii_rd_1     = rd1_q;
    assign rgmii_rd_2     = rd2_q;
    assign rgmii_rx_ctl_1 = ctl1_q;
    assign rgmii_rx_ctl_2 = ctl2_q;

endmodule

// File: tb/tb_rgmii_phy_side_tx.sv
// Bench for rgmii_phy_side_tx: random byte stream and speed changes against a segment-level model.
// Each sampled byte expands into a run of expected wire cycles; status nibbles are evaluated live.
module tb_rgmii_phy_side_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] speed;
    logic       link_up;
    logic       full_duplex;
    logic [7:0] s_rxd;
    logic       s_rx_dv;
    logic       s_rx_er;
    logic       s_rx_en;
    logic       rgmii_rxc_1;
    logic       rgmii_rxc_2;
    logic [3:0] rgmii_rd_1;
    logic [3:0] rgmii_rd_2;
    logic       rgmii_rx_ctl_1;
    logic       rgmii_rx_ctl_2;

    always #4 clk = ~clk;

    rgmii_phy_side_tx #(.DIV_100M(5), .DIV_10M(50)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .speed          (speed),
        .link_up        (link_up),
        .full_duplex    (full_duplex),
        .s_rxd          (s_rxd),
        .s_rx_dv        (s_rx_dv),
        .s_rx_er        (s_rx_er),
        .s_rx_en        (s_rx_en),
        .rgmii_rxc_1    (rgmii_rxc_1),
        .rgmii_rxc_2    (rgmii_rxc_2),
        .rgmii_rd_1     (rgmii_rd_1),
        .rgmii_rd_2     (rgmii_rd_2),
        .rgmii_rx_ctl_1 (rgmii_rx_ctl_1),
        .rgmii_rx_ctl_2 (rgmii_rx_ctl_2)
    );

    // {en, rxc_1, rxc_2, ctl_1, ctl_2, rd_2, rd_1}
    logic [12:0] obs_vec;
    assign obs_vec = {s_rx_en, rgmii_rxc_1, rgmii_rxc_2, rgmii_rx_ctl_1, rgmii_rx_ctl_2,
                      rgmii_rd_2, rgmii_rd_1};

    localparam logic [12:0] RST_VEC = 13'b0_1_0_0_0_0000_0000;

    typedef struct {
        int         kind;   // 0 reset hold, 1 status, 2 data
        logic [1:0] spd;
        logic [7:0] b;
        logic       dv;
        logic       er;
        int         pos;
        logic       last;
    } seg_t;

    seg_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] cur_spd;
    logic [1:0] phase_spd;
    logic       prev_link, prev_fd;
    logic       in_frame;
    bit         rand_speed;
    bit         hit_hi100;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic int per(input logic [1:0] s);
        return (s == 2'b01) ? 5 : ((s == 2'b00) ? 50 : 1);
    endfunction

    task automatic push_seg(input int kind, input logic [1:0] spd, input logic [7:0] b,
                            input logic dv, input logic er, input int len);
        seg_t e;
        for (int i = 0; i < len; i++) begin
            e.kind = kind; e.spd = spd; e.b = b; e.dv = dv; e.er = er;
            e.pos = i; e.last = (i == len - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        seg_t e;
        exp_q.delete();
        cur_spd = 2'b10;
        e.kind = 0; e.spd = 2'b10; e.b = 8'h00; e.dv = 1'b0; e.er = 1'b0; e.pos = 0; e.last = 1'b0;
        exp_q.push_back(e);
        push_seg(1, 2'b10, 8'h00, 1'b0, 1'b0, 1);
    endtask

    // called at the negedge: checks the current wire cycle, then accounts for the upcoming sample
    task automatic model_step();
        seg_t        e;
        logic [12:0] ex;
        int          p, h, c;
        logic [3:0]  st, nb;
        logic        r, ct;
        string       tag;
        e  = exp_q.pop_front();
        p  = per(e.spd);
        h  = p / 2;
        c  = e.pos % p;
        st = {prev_fd, e.spd, prev_link};
        r  = (c >= h);
        ex = RST_VEC;
        tag = "reset_out";
        if (e.kind == 1) begin
            tag = "status";
            ex = (p == 1) ? {e.last, 1'b1, 1'b0, 2'b00, st, st}
                          : {e.last, r, r, 2'b00, st, st};
        end else if (e.kind == 2) begin
            tag = "data";
            if (p == 1) begin
                ex = {e.last, 1'b1, 1'b0, e.dv, e.dv ^ e.er, e.b[7:4], e.b[3:0]};
            end else begin
                nb = (e.pos < p) ? e.b[3:0] : e.b[7:4];
                ct = r ? (e.dv ^ e.er) : e.dv;
                ex = {e.last, r, r, ct, ct, nb, nb};
            end
        end
        check_eq(tag, 32'(obs_vec), 32'(ex));
        hit_hi100 = (e.kind == 2) && (e.spd == 2'b01) && (e.pos >= p);
        if (e.last) begin
            if (s_rx_dv | s_rx_er) begin
                push_seg(2, cur_spd, s_rxd, s_rx_dv, s_rx_er,
                         (per(cur_spd) == 1) ? 1 : 2 * per(cur_spd));
            end else begin
                cur_spd = speed;
                push_seg(1, cur_spd, 8'h00, 1'b0, 1'b0, per(cur_spd));
            end
        end
    endtask

    task automatic drive_inputs();
        prev_link = link_up;
        prev_fd   = full_duplex;
        if ($urandom_range(0, 15) == 0) link_up = ~link_up;
        if ($urandom_range(0, 15) == 0) full_duplex = ~full_duplex;
        if (in_frame) in_frame = ($urandom_range(0, 7) != 0);
        else          in_frame = ($urandom_range(0, 3) == 0);
        s_rx_dv = in_frame;
        s_rx_er = ($urandom_range(0, 9) == 0);
        s_rxd   = 8'($urandom);
        if (rand_speed) begin
            if ($urandom_range(0, 299) == 0) speed = 2'($urandom_range(0, 3));
        end else begin
            speed = phase_spd;
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1 drive_inputs();
        @(negedge clk);
        model_step();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        model_step();
    endtask

    initial begin
        rst_n = 1'b0; speed = 2'b10; phase_spd = 2'b10; link_up = 1'b1; full_duplex = 1'b1;
        s_rxd = 8'h00; s_rx_dv = 1'b0; s_rx_er = 1'b0; in_frame = 1'b0;
        rand_speed = 1'b0; hit_hi100 = 1'b0; prev_link = 1'b1; prev_fd = 1'b1; cur_spd = 2'b10;

        repeat (2) begin
            @(negedge clk);
            check_eq("reset_hold", 32'(obs_vec), 32'(RST_VEC));
        end
        release_reset();

        phase_spd = 2'b10; repeat (1500) run_cycle();
        phase_spd = 2'b01; repeat (3000) run_cycle();
        phase_spd = 2'b00; repeat (6000) run_cycle();
        phase_spd = 2'b11; repeat (1000) run_cycle();
        rand_speed = 1'b1;  repeat (6000) run_cycle();

        // asynchronous reset landing in the high-nibble half of a 100M frame byte
        rand_speed = 1'b0; phase_spd = 2'b01;
        hit_hi100 = 1'b0;
        for (int i = 0; i < 3000 && !hit_hi100; i++) run_cycle();
        check_eq("nib_hi_window", 32'(hit_hi100), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_eq("async_rst", 32'(obs_vec), 32'(RST_VEC));
        phase_spd = 2'b10; speed = 2'b10;
        in_frame = 1'b0; s_rx_dv = 1'b0; s_rx_er = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("reset_hold", 32'(obs_vec), 32'(RST_VEC));
        end
        release_reset();
        repeat (200) run_cycle();
        rand_speed = 1'b1; repeat (2000) run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
